// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, full/empty, almost flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo_flags #(
    parameter int BIT_WIDTH       = 8,
    parameter int FIFO_SIZE       = 16,
    parameter int ALMOST_FULL_TH  = FIFO_SIZE - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    localparam int ADDR_BITW      = $clog2(FIFO_SIZE),
    localparam int CNT_BITW       = ADDR_BITW + 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [BIT_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    output logic [BIT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic [CNT_BITW-1:0]  count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);
    localparam logic [CNT_BITW-1:0] AF_TH = CNT_BITW'(ALMOST_FULL_TH);
    localparam logic [CNT_BITW-1:0] AE_TH = CNT_BITW'(ALMOST_EMPTY_TH);
    localparam logic [CNT_BITW-1:0] ONE   = CNT_BITW'(1);

    logic [BIT_WIDTH-1:0] mem_q [FIFO_SIZE];
    logic [CNT_BITW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d, underflow_q, underflow_d;
    logic                 wr_acc, rd_acc;
    logic [BIT_WIDTH-1:0] head;

    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign full         = (wr_ptr_q[ADDR_BITW] != rd_ptr_q[ADDR_BITW]) &&
                          (wr_ptr_q[ADDR_BITW-1:0] == rd_ptr_q[ADDR_BITW-1:0]);
    assign almost_empty = count <= AE_TH;
    assign almost_full  = count >= AF_TH;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign wr_acc       = wr_en && !full && !clear;
    assign rd_acc       = rd_en && !empty && !clear;
    assign head         = mem_q[rd_ptr_q[ADDR_BITW-1:0]];

    // Next pointers and sticky error flags; flush overrides any request in the same cycle.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_ptr_d    = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
            rd_ptr_d    = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
            overflow_d  = overflow_q | (wr_en && full);
            underflow_d = underflow_q | (rd_en && empty);
        end
    end

    // Pointer and error flag registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; stale words past the pointers are never observable, so no reset.
    always_ff @(posedge clock) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_BITW-1:0]] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : head;
`else
    logic [BIT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    // A word popped on this edge is presented for exactly one cycle; zero otherwise.
    always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? head : '0;
    end

    // Registered read port.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: randomized and directed checks of sync_fifo_flags against a queue model.
module tb_sync_fifo_flags;
    localparam int BW = 8;
    localparam int FS = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [BW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    count;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    int tests = 0;
    int fails = 0;

    logic [BW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          m_valid = 1'b0;
    logic [BW-1:0] m_data = '0;

    sync_fifo_flags #(
        .BIT_WIDTH(BW), .FIFO_SIZE(FS), .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)
    ) dut (
        .clock(clock), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
        m_valid = n != 0;
        m_data  = n != 0 ? q[0] : '0;
`endif
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == FS));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_data));
    endtask

    task automatic step(input logic w, input logic [BW-1:0] d, input logic r, input logic c);
        int n;
        logic [BW-1:0] popped;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clear   = c;
        @(posedge clock);
        n = q.size();
        if (c) begin
            model_reset();
        end else begin
            popped  = '0;
            m_valid = 1'b0;
            if (r && n == 0) m_unf = 1'b1;
            if (r && n != 0) begin
                popped  = q.pop_front();
                m_valid = 1'b1;
            end
            m_data = popped;
            if (w && n == FS) m_ovf = 1'b1;
            if (w && n != FS) q.push_back(d);
        end
        #1;
        check_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        rst = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        #12;
        model_reset();
        check_all();
        @(negedge clock);
        rst = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < 5; i++) step(1'b1, BW'(8'h11 * (i + 1)), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, BW'(2 * i), 1'b0, 1'b0);
            step(1'b1, BW'(2 * i + 1), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b1, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, BW'(8'hB0 + i), 1'b1, 1'b0);
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = (i / 100) % 2 == 0 ? 75 : 30;
            rp = 100 - wp;
            step($urandom_range(0, 99) < wp, BW'($urandom), $urandom_range(0, 99) < rp,
                 $urandom_range(0, 99) < 3);
            if (i == 333) async_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
